// File: rtl/logic_gate_unit.sv
// Registered bitwise gate with a valid/ready handshake, plus a self-test sweep
// that runs every (a,b) combination through the latched op and folds the results into a signature.
module logic_gate_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [15:0]      sweep_sig
);

  localparam int CW = 2 * WIDTH;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      sig_q, sig_d;
  logic [15:0]      sweep_sig_q, sweep_sig_d;

  logic             accept;
  logic             sweep_ok;
  logic [WIDTH-1:0] sweep_r;

  function automatic logic [WIDTH-1:0] gate_f(input logic [2:0] sel,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] res;
    res = x;
    case (sel)
      3'd0: res = ~(x & y);
      3'd1: res = x & y;
      3'd2: res = x | y;
      3'd3: res = ~(x | y);
      3'd4: res = x ^ y;
      3'd5: res = ~(x ^ y);
      3'd6: res = ~x;
      default: res = x;
    endcase
    return res;
  endfunction

  // A start request blocks operand acceptance even when it will not be honoured.
  assign in_ready   = (state_q == IDLE) && !sweep_start && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign sweep_ok   = (state_q == IDLE) && sweep_start && !out_valid_q;
  assign sweep_r    = gate_f(op_q, cnt_q[CW-1:WIDTH], cnt_q[WIDTH-1:0]);

  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign sweep_busy = (state_q == SWEEP) || (state_q == DONE);
  assign sweep_done = (state_q == DONE);
  assign sweep_sig  = (state_q == DONE) ? sig_q : sweep_sig_q;

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    sig_d       = sig_q;
    sweep_sig_d = sweep_sig_q;

    if (accept) begin
      out_d       = gate_f(op, a, b);
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (sweep_ok) begin
          state_d = SWEEP;
          op_d    = op;
          cnt_d   = '0;
          sig_d   = '0;
        end
      end
      SWEEP: begin
        sig_d = {sig_q[14:0], sig_q[15]} ^ {{(16-WIDTH){1'b0}}, sweep_r};
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_MAX) state_d = DONE;
      end
      DONE: begin
        sweep_sig_d = sig_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      op_q        <= 3'd0;
      cnt_q       <= '0;
      sig_q       <= '0;
      sweep_sig_q <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      sig_q       <= sig_d;
      sweep_sig_q <= sweep_sig_d;
    end
  end

endmodule

// File: doc/logic_gate_unit.md
LOGIC_GATE_UNIT -- requirements
Module: logic_gate_unit

Interface
REQ-001 Parameter WIDTH, default 4, is the operand and result width in bits; legal range 1..8.
REQ-002 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  is the synchronous, active-low reset.
REQ-004 in_valid  input  1  means the operand set (op, a, b) is valid this cycle.
REQ-005 in_ready  output  1  means the unit accepts the operand set this cycle.
REQ-006 op  input  3  selects the gate: 0 NAND, 1 AND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 BUF a.
REQ-007 a  input  WIDTH  is operand A.
REQ-008 b  input  WIDTH  is operand B; it is ignored for op 6 and op 7.
REQ-009 out_valid  output  1  means out holds a valid result.
REQ-010 out_ready  input  1  means the downstream consumer takes out this cycle.
REQ-011 out  output  WIDTH  is the registered bitwise result.
REQ-012 sweep_start  input  1  requests an exhaustive truth-table sweep of op.
REQ-013 sweep_busy  output  1  is high while the sweep runs.
REQ-014 sweep_done  output  1  is a one-cycle pulse when the sweep completes.
REQ-015 sweep_sig  output  16  is the signature of the last completed sweep.

Function
REQ-016 The gate function SHALL be bitwise across all WIDTH bits per the op encoding in REQ-006.
REQ-017 FSM states SHALL be IDLE, SWEEP and DONE.
REQ-018 in_ready SHALL equal (state==IDLE) && !sweep_start && (!out_valid || out_ready), combinationally.
REQ-019 An accept (in_valid && in_ready) in cycle T SHALL present the result on out with out_valid=1 in cycle T+1, giving latency 1.
REQ-020 While out_valid && !out_ready, out and out_valid SHALL hold stable.
REQ-021 With out_valid && out_ready and no accept, out_valid SHALL clear next cycle; out keeps its last value.
REQ-022 With out_valid && out_ready and an accept in the same cycle, a back-to-back transfer SHALL occur at full throughput of one result per cycle.
REQ-023 sweep_start SHALL be honoured only in IDLE with out_valid=0; otherwise it SHALL be ignored, with no queuing.
REQ-024 If sweep_start and in_valid are both high when IDLE with out_valid=0, the sweep SHALL win and the operand SHALL NOT be accepted.
REQ-025 On an honoured start in cycle T: op SHALL be latched, counter cnt (2*WIDTH bits) set to 0, internal signature cleared to 0, and state moved to SWEEP at T+1.
REQ-026 In each SWEEP cycle, {a_int,b_int}=cnt with a_int as the MSBs; r=gate(op_latched,a_int,b_int); sig <= rotl1(sig) ^ zero-extend(r); cnt increments.
REQ-027 After the cycle with cnt = 2^(2*WIDTH)-1, the FSM SHALL go to DONE, so SWEEP lasts exactly 2^(2*WIDTH) cycles.
REQ-028 In DONE, sweep_done=1 and sweep_sig is updated from sig for one cycle; the FSM then returns to IDLE.
REQ-029 sweep_sig SHALL hold its value until the next DONE.
REQ-030 sweep_busy SHALL be 1 exactly in SWEEP and DONE.
REQ-031 in_ready SHALL be 0 throughout SWEEP and DONE.
REQ-032 The sweep SHALL NOT drive out or out_valid.
REQ-033 The sweep SHALL ignore a, b, op, in_valid and sweep_start while running.

Reset
REQ-034 While rst_n=0 at a clock edge: out_valid=0, out=0, state=IDLE, cnt=0, sig=0, sweep_sig=0, sweep_done=0, sweep_busy=0.
REQ-035 Reset asserted mid-sweep or mid-backpressure SHALL abort the operation with no sweep_done pulse; the first accept is possible in the cycle after rst_n returns high.

Verification
REQ-036 Single op: WIDTH=1, op=0, (a,b) = 00, 01, 10, 11 in consecutive accepts with out_ready=1 -> out = 1, 1, 1, 0, each one cycle after its accept.
REQ-037 Backpressure: WIDTH=4, op=4, a=0xA, b=0x6, out_ready=0 -> out=0xC, out_valid=1 held; in_ready=0 with a second operand pending; raise out_ready -> second result next cycle.
REQ-038 Sweep: WIDTH=1, op=0, sweep_start at T -> busy from T+1, sweep_done at T+5, sweep_sig=0x000E.
REQ-039 Contention: sweep_start and in_valid high together in IDLE -> in_ready=0, operand not accepted, sweep runs.
REQ-040 Ignored start: sweep_start while out_valid=1 -> no state change, sweep_busy stays 0.
REQ-041 Reset mid-sweep: rst_n=0 during SWEEP -> all outputs 0 next cycle, no sweep_done, in_ready=1 after release.
